// File: rtl/trigger_monitor.sv
// ============================================================================
// Module   : trigger_monitor
// Purpose  : Receive-side checker for the periodic active-low trigger. It
//            measures the trigger period, locks after repeated correct
//            periods and raises sticky errors.
//            Optional define TRIG_MON_TIMEOUT_EN adds a missing-pulse timeout.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trigger_monitor #(
    parameter int N        = 2,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             nul,
    output logic             pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             miss
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [CNT_W-1:0] C_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_N    = N[CNT_W-1:0];
    localparam logic [3:0]       C_LOCK = LOCK_CNT[3:0];

`ifdef TRIG_MON_TIMEOUT_EN
    localparam int               C_TO_INT  = ((2 * N - 1) > ((2 ** CNT_W) - 1)) ?
                                             ((2 ** CNT_W) - 1) : (2 * N - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = C_TO_INT[CNT_W-1:0];
    logic                        w_timeout;
    logic                        r_miss;
`endif

    logic             r_trig_q;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [3:0]       r_match_cnt;
    logic [1:0]       r_state;
    logic             r_pulse;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_err;

    logic             w_low;
    logic [CNT_W-1:0] w_meas;
    logic             w_period_ok;
    logic [3:0]       w_inc_match;
    logic [1:0]       w_next_state;
    logic [3:0]       w_next_match;
    logic             w_set_err;
    logic [CNT_W-1:0] w_next_gap;

    always_comb begin
        w_low        = ~r_trig_q;
        // A saturated measurement can never equal N, so it always mismatches.
        w_meas       = (r_gap_cnt == C_MAX) ? C_MAX : (r_gap_cnt + C_ONE);
        w_period_ok  = (w_meas == C_N);
        w_inc_match  = r_match_cnt + 4'd1;
        w_next_gap   = w_low ? '0 : ((r_gap_cnt == C_MAX) ? C_MAX : (r_gap_cnt + C_ONE));
        w_next_state = r_state;
        w_next_match = r_match_cnt;
        w_set_err    = 1'b0;
`ifdef TRIG_MON_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        if (w_low) begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_ACQ;
                    w_next_match = 4'd0;
                end
                S_ACQ, S_ERR: begin
                    if (w_period_ok) begin
                        w_next_match = w_inc_match;
                        if (w_inc_match == C_LOCK) begin
                            w_next_state = S_LOCKED;
                        end
                    end else begin
                        w_next_match = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (!w_period_ok) begin
                        w_next_state = S_ERR;
                        w_next_match = 4'd0;
                        w_set_err    = 1'b1;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_match = 4'd0;
                end
            endcase
        end
`ifdef TRIG_MON_TIMEOUT_EN
        else if ((r_state == S_LOCKED) && (r_gap_cnt == C_TIMEOUT)) begin
            w_timeout    = 1'b1;
            w_next_state = S_ERR;
            w_next_match = 4'd0;
            w_set_err    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_q       <= 1'b1;
            r_gap_cnt      <= '0;
            r_match_cnt    <= 4'd0;
            r_state        <= S_IDLE;
            r_pulse        <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_trig_q <= trigger;
            // Restart discards any coincident low sample; period is kept.
            if (!nul) begin
                r_gap_cnt      <= '0;
                r_match_cnt    <= 4'd0;
                r_state        <= S_IDLE;
                r_pulse        <= 1'b0;
                r_period_valid <= 1'b0;
                r_locked       <= 1'b0;
                r_err          <= 1'b0;
            end else begin
                r_gap_cnt      <= w_next_gap;
                r_match_cnt    <= w_next_match;
                r_state        <= w_next_state;
                r_pulse        <= w_low;
                r_period_valid <= w_low && (r_state != S_IDLE);
                r_locked       <= (w_next_state == S_LOCKED);
                if (w_low && (r_state != S_IDLE)) begin
                    r_period <= w_meas;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef TRIG_MON_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || !nul) begin
            r_miss <= 1'b0;
        end else begin
            r_miss <= w_timeout;
        end
    end
    assign miss = r_miss;
`else
    assign miss = 1'b0;
`endif

    assign pulse        = r_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign err          = r_err;

endmodule

`default_nettype wire
